// File: rtl/lap_pkg.sv
// Shared lap-memory definitions used by the counter, the lap memory and the readers.
package lap_pkg;

  localparam int LAP_DATA_W = 8;
  localparam int LAP_ADDR_W = 3;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_PRESENT,
    RD_DONE
  } lap_rd_state_t;

endpackage

// File: rtl/lap_rd_lat_cnt.sv
// Loadable down-counter that times the read-latency wait of a memory reader.
// tc is high while the count sits at zero.
module lap_rd_lat_cnt
  import lap_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  // load has priority; otherwise count down to zero and stop there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/lap_mem_reader.sv
// Lap memory read-back: streams recorded entries in address order over a
// valid/ready port, one synchronous memory read per beat.
// Build option: define LAP_READER_DIFF_EN to output split times
// (entry minus previous entry) instead of absolute values.
//
// state      | meaning
// RD_IDLE    | waiting for dump_start
// RD_ISSUE   | one-cycle memory read strobe for entry idx
// RD_WAIT    | waiting RD_LATENCY cycles, capture read data on the last one
// RD_PRESENT | beat held on the output until accepted
// RD_DONE    | one-cycle done pulse
module lap_mem_reader
  import lap_pkg::*;
#(
  parameter int DATA_W     = LAP_DATA_W,
  parameter int ADDR_W     = LAP_ADDR_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start,
  input  logic              abort,
  input  logic [ADDR_W:0]   entry_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;

  lap_rd_state_t     state, state_next;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_clamp;
  logic [DATA_W-1:0] data_q;
  logic              lat_load;
  logic              lat_tc;
  logic              handshake;
  logic              is_last;
  logic              start_ok;

  assign cnt_clamp = (entry_count > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : entry_count;
  assign handshake = (state == RD_PRESENT) && out_ready;
  assign is_last   = ({1'b0, idx} == (cnt - 1'b1));
  assign start_ok  = (state == RD_IDLE) && dump_start && !abort;

  lap_rd_lat_cnt #(.W(2)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (2'(RD_LATENCY - 1)),
    .en       (state == RD_WAIT),
    .tc       (lat_tc)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RD_IDLE;
    else      state <= state_next;
  end

  // next-state decode; abort overrides everything and returns to idle
  always_comb begin
    state_next = state;
    lat_load   = 1'b0;
    case (state)
      RD_IDLE:    if (dump_start) state_next = (cnt_clamp == '0) ? RD_DONE : RD_ISSUE;
      RD_ISSUE: begin
        lat_load   = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT:    if (lat_tc) state_next = RD_PRESENT;
      RD_PRESENT: if (out_ready) state_next = is_last ? RD_DONE : RD_ISSUE;
      RD_DONE:    state_next = RD_IDLE;
      default:    state_next = RD_IDLE;
    endcase
    if (abort) state_next = RD_IDLE;
  end

  // dump bookkeeping: latched count, entry index and captured read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      idx    <= '0;
      data_q <= '0;
    end else begin
      if (start_ok) begin
        cnt <= cnt_clamp;
        idx <= '0;
      end
      if ((state == RD_WAIT) && lat_tc) data_q <= mem_rd_data;
      if (handshake && !is_last) idx <= idx + 1'b1;
    end
  end

`ifdef LAP_READER_DIFF_EN
  logic [DATA_W-1:0] prev;

  // previous delivered entry, the reference for the split time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           prev <= '0;
    else if (start_ok)  prev <= '0;
    else if (handshake) prev <= data_q;
  end

  assign out_data = data_q - prev;
`else
  assign out_data = data_q;
`endif

  assign mem_rd_en = (state == RD_ISSUE);
  assign mem_addr  = idx;
  assign out_valid = (state == RD_PRESENT);
  assign out_index = idx;
  assign out_last  = (state == RD_PRESENT) && is_last;
  assign busy      = (state != RD_IDLE);
  assign done      = (state == RD_DONE);

endmodule

// File: tb/tb_lap_mem_reader.sv
// Directed bench for lap_mem_reader with a one-cycle-latency memory model.
module tb_lap_mem_reader;
  import lap_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dump_start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   entry_count = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  lap_mem_reader #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .dump_start  (dump_start),
    .abort       (abort),
    .entry_count (entry_count),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  // lap memory: synchronous read, data one cycle after the strobe
  logic [DW-1:0] mem [8];
  logic [DW-1:0] rd_q = '0;
  always @(posedge clk) if (mem_rd_en) rd_q <= mem[mem_addr];
  assign mem_rd_data = rd_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            rd_cnt, done_cnt, valid_cnt, first_valid, hs_edge, done_edge, max_addr;
  logic [DW-1:0] b_data[$];
  logic [AW-1:0] b_idx[$];
  logic          b_last[$];
  logic [DW-1:0] exp_d[8];
  int            n_chk = 0;
  int            n_pass = 0;
  int            e0;

  // monitor sampled mid-cycle; a handshake seen here completes on the next edge
  always @(negedge clk) begin
    if (rst) begin
      if (mem_rd_en) begin
        rd_cnt++;
        if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
      end
      if (done) begin
        done_cnt++;
        done_edge = cyc;
      end
      if (out_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc + 1;
      end
      if (out_valid && out_ready) begin
        b_data.push_back(out_data);
        b_idx.push_back(out_index);
        b_last.push_back(out_last);
        hs_edge = cyc + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    rd_cnt = 0; done_cnt = 0; valid_cnt = 0; first_valid = -1;
    hs_edge = -1; done_edge = -2; max_addr = -1;
    b_data.delete(); b_idx.delete(); b_last.delete();
  endtask

  task automatic start_dump(input int n);
    entry_count = (AW+1)'(n);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done();
    int start;
    start = done_cnt;
    for (int k = 0; k < 200; k++) begin
      if (done_cnt != start) break;
      tick();
    end
    check("done_timeout", 32'(done_cnt != start), 1);
    tick();
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 30; k++) begin
      if (out_valid) break;
      tick();
    end
    check("valid_timeout", 32'(out_valid), 1);
  endtask

  task automatic check_beats(input string tag, input int n);
    check({tag, "_nbeats"}, b_data.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < b_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), 32'(b_data[i]), 32'(exp_d[i]));
        check($sformatf("%s_idx%0d", tag, i), 32'(b_idx[i]), i);
        check($sformatf("%s_last%0d", tag, i), 32'(b_last[i]), 32'(i == n - 1));
      end
    end
  endtask

  initial begin
    clear_stats();
    #12;
    check("rst_outputs", {out_valid, busy, mem_rd_en, done, out_last, out_data, mem_addr, out_index}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // T1 stream
    mem[0] = 8'h05; mem[1] = 8'h0C; mem[2] = 8'h20;
`ifdef LAP_READER_DIFF_EN
    exp_d[0] = 8'h05; exp_d[1] = 8'h07; exp_d[2] = 8'h14;
`else
    exp_d[0] = 8'h05; exp_d[1] = 8'h0C; exp_d[2] = 8'h20;
`endif
    clear_stats();
    out_ready = 1'b1;
    start_dump(3);
    wait_done();
    check_beats("t1", 3);
    check("t1_first_valid", first_valid, e0 + 3);
    check("t1_done_edge", done_edge, hs_edge);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_rd_cnt", rd_cnt, 3);

    // T2 backpressure, with a stray dump_start while busy
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
`ifdef LAP_READER_DIFF_EN
    exp_d[0] = 8'h11; exp_d[1] = 8'h11; exp_d[2] = 8'h11;
`else
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
`endif
    clear_stats();
    out_ready = 1'b0;
    start_dump(3);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      check("t2_hold_valid", 32'(out_valid), 1);
      check("t2_hold_data", 32'(out_data), 32'h11);
      check("t2_hold_rd_en", 32'(mem_rd_en), 0);
      if (k == 2) dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
    end
    check("t2_hold_index", 32'(out_index), 0);
    check("t2_no_reads", rd_cnt, 1);
    out_ready = 1'b1;
    wait_done();
    check_beats("t2", 3);
    check("t2_done_cnt", done_cnt, 1);

    // T3 empty dump
    clear_stats();
    start_dump(0);
    wait_done();
    check("t3_empty_rd", rd_cnt, 0);
    check("t3_empty_valid", valid_cnt, 0);
    check("t3_empty_done", done_cnt, 1);

    // T3 clamp: 9 requested, 8 delivered; mid-dump entry_count change ignored
    for (int i = 0; i < 8; i++) begin
      mem[i] = 8'(i * 3 + 1);
`ifdef LAP_READER_DIFF_EN
      exp_d[i] = (i == 0) ? 8'h01 : 8'h03;
`else
      exp_d[i] = 8'(i * 3 + 1);
`endif
    end
    clear_stats();
    start_dump(9);
    tick();
    tick();
    entry_count = 4'd2;
    wait_done();
    check_beats("t3", 8);
    check("t3_max_addr", max_addr, 7);
    check("t3_rd_cnt", rd_cnt, 8);

    // T4 abort during WAIT of entry 1
    mem[0] = 8'h05; mem[1] = 8'h0C; mem[2] = 8'h20;
`ifdef LAP_READER_DIFF_EN
    exp_d[0] = 8'h05; exp_d[1] = 8'h07; exp_d[2] = 8'h14;
`else
    exp_d[0] = 8'h05; exp_d[1] = 8'h0C; exp_d[2] = 8'h20;
`endif
    clear_stats();
    start_dump(3);
    for (int k = 0; k < 20; k++) begin
      if (mem_rd_en && mem_addr == 3'd1) break;
      tick();
    end
    check("t4_issue1_seen", 32'(mem_rd_en && mem_addr == 3'd1), 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_busy", 32'(busy), 0);
    check("t4_abort_valid", 32'(out_valid), 0);
    for (int k = 0; k < 5; k++) tick();
    check("t4_no_done", done_cnt, 0);
    check("t4_beats_before", b_data.size(), 1);
    clear_stats();
    start_dump(3);
    wait_done();
    check_beats("t4r", 3);

    // T5 split-time wrap
    mem[0] = 8'h05; mem[1] = 8'h0C; mem[2] = 8'h03;
`ifdef LAP_READER_DIFF_EN
    exp_d[0] = 8'h05; exp_d[1] = 8'h07; exp_d[2] = 8'hF7;
`else
    exp_d[0] = 8'h05; exp_d[1] = 8'h0C; exp_d[2] = 8'h03;
`endif
    clear_stats();
    start_dump(3);
    wait_done();
    check_beats("t5", 3);

    // T6 async reset while presenting
    clear_stats();
    out_ready = 1'b0;
    start_dump(3);
    wait_valid();
    #1 rst = 1'b0;
    #1 check("t6_rst_outputs", {out_valid, busy, mem_rd_en}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("t6_not_resumed", 32'(busy), 0);
    check("t6_no_done", done_cnt, 0);
    check("t6_no_beats", b_data.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
